// File: rtl/b4_sipo_rx.sv
// rtl/b4_sipo_rx.sv - serial-in parallel-out receiver with divided-clock sampling and valid/ack output
module b4_sipo_rx #(
  parameter int WIDTH    = 4,
  parameter int DIV_BITS = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             D_in,
  input  logic             ack,
  output logic [WIDTH-1:0] Q_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [DIV_BITS-1:0] div;
  logic                tick;
  state_t              state;
  logic [CW-1:0]       count;
  logic [WIDTH-1:0]    sreg;
  logic [WIDTH-1:0]    word;
  logic                last;
  logic                complete;

  assign tick     = &div;
  assign word     = {D_in, sreg[WIDTH-1:1]};
  assign last     = (count == CW'(WIDTH - 1));
  assign complete = tick && en && (state == SHIFT) && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else begin
      div <= div + DIV_BITS'(1);
    end
  end

  // Frame FSM only advances on tick cycles; busy mirrors the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      sreg  <= '0;
      busy  <= 1'b0;
    end else if (tick) begin
      if (!en) begin
        state <= IDLE;
        count <= '0;
        sreg  <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sreg  <= word;
            count <= CW'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
          SHIFT: begin
            sreg <= word;
            if (last) begin
              count <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              count <= count + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
            sreg  <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A completing word is accepted when the slot is free or being freed this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q_out   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (complete) begin
      if (!valid || ack) begin
        Q_out <= word;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b4_sipo_rx.sv
// tb/tb_b4_sipo_rx.sv - scoreboard bench for b4_sipo_rx with a bit-list reference model
module tb_b4_sipo_rx;

  localparam int WIDTH    = 4;
  localparam int DIV_BITS = 2;
  localparam int PERIOD   = 1 << DIV_BITS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             D_in = 1'b0;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] Q_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  bit m_bits[$];
  bit m_valid;
  bit m_ovr;
  int m_q;

  b4_sipo_rx #(.WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) dut (
    .clk(clk), .rst(rst), .en(en), .D_in(D_in), .ack(ack),
    .Q_out(Q_out), .valid(valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every newly presented word is popped from the scoreboard.
  logic             prev_valid = 1'b0;
  logic [WIDTH-1:0] prev_q = '0;
  always @(negedge clk) begin
    if (rst && valid && (!prev_valid || Q_out != prev_q)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", int'(Q_out), -1);
      end else begin
        chk("word", int'(Q_out), exp_q.pop_front());
      end
    end
    prev_valid = valid;
    prev_q     = Q_out;
  end

  task automatic model_reset();
    m_bits.delete();
    m_valid = 0;
    m_ovr   = 0;
    m_q     = 0;
  endtask

  task automatic do_reset(input bit check_zero);
    rst = 1'b0;
    en = 1'b0; D_in = 1'b0; ack = 1'b0;
    #1;
    model_reset();
    if (check_zero) begin
      chk("rst_q", int'(Q_out), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One sample period: PERIOD edges, the last of which is the tick edge.
  task automatic do_period(input bit d, input bit e, input bit ack_first, input bit ack_last);
    int word;
    D_in = d; en = e; ack = ack_first;
    @(posedge clk); #1;
    ack = 1'b0;
    if (ack_first) begin
      m_valid = 0;
      chk("ack_clears_valid", int'(valid), 0);
    end
    repeat (PERIOD - 2) begin @(posedge clk); #1; end
    ack = ack_last;
    @(posedge clk); #1;
    ack = 1'b0;
    if (!e) begin
      m_bits.delete();
      if (ack_last) m_valid = 0;
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == WIDTH) begin
        word = 0;
        foreach (m_bits[i]) word += int'(m_bits[i]) << i;
        m_bits.delete();
        if (!m_valid || ack_last) begin
          m_valid = 1;
          m_q     = word;
          exp_q.push_back(word);
        end else begin
          m_ovr = 1;
        end
      end else if (ack_last) begin
        m_valid = 0;
      end
    end
    chk("valid", int'(valid), int'(m_valid));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("busy", int'(busy), int'(m_bits.size() > 0));
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit ack_first, input bit ack_last);
    for (int i = 0; i < WIDTH; i++)
      do_period(w[i], 1'b1, (i == 0) && ack_first, (i == WIDTH - 1) && ack_last);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(1'b1);

    // basic frame 1,1,0,1 then ack
    send_frame(4'hB, 1'b0, 1'b0);
    chk("basic_q", int'(Q_out), 'hB);
    do_period(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ack_q_held", int'(Q_out), 'hB);

    // overrun: B accepted, 6 dropped, ack clears valid only
    send_frame(4'hB, 1'b0, 1'b0);
    send_frame(4'h6, 1'b0, 1'b0);
    chk("ovr_q_held", int'(Q_out), 'hB);
    do_period(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_sticky", int'(overrun), 1);

    // ack/complete collision
    do_reset(1'b1);
    send_frame(4'hB, 1'b0, 1'b0);
    send_frame(4'h6, 1'b0, 1'b1);
    chk("collide_q", int'(Q_out), 'h6);

    // abort after two bits
    do_period(1'b1, 1'b1, 1'b1, 1'b0);
    do_period(1'b1, 1'b1, 1'b0, 1'b0);
    do_period(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'h1, 1'b0, 1'b0);
    chk("abort_q", int'(Q_out), 'h1);

    // reset mid-frame after three bits
    for (int i = 0; i < 3; i++) do_period(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1'b1);
    send_frame(4'hA, 1'b0, 1'b0);
    chk("post_reset_q", int'(Q_out), 'hA);

    // randomized frames with occasional acks and aborts
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(1, WIDTH - 1);
        for (int i = 0; i < k; i++) do_period(1'($urandom), 1'b1, 1'b0, 1'b0);
        do_period(1'($urandom), 1'b0, 1'b0, 1'b0);
      end
      send_frame(WIDTH'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
    end

    do_period(1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
